// File: rtl/learn_pkg.sv
// Shared types and helpers for the learn-mode tutor.
// Imported by the tutor top and its edge detector.
package learn_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_PROMPT,
    S_RELEASE,
    S_ADV,
    S_DONE
  } state_t;

  localparam int NOTE_REST = 0;
  // Cast to NOTE_W bits this becomes the all-ones marker.
  localparam int NOTE_END  = -1;

  // Index width for v entries, never narrower than 1 bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/learn_edge_det.sv
// Rising-edge detector against a one-cycle delayed copy.
// Width is a parameter so one instance can cover a bundle.
module learn_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_d;
  logic [W-1:0] prev_q;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/learn_tutor.sv
// Learn-mode tutor: walks a song from the library ROM,
// prompts each note on the LEDs and scores the player.
module learn_tutor
  import learn_pkg::*;
#(
  parameter int NUM_KEYS  = 7,
  parameter int NUM_SONGS = 3,
  parameter int SONG_LEN  = 56,
  parameter int NOTE_W    = 4,
  parameter int OCT_W     = 2,
  parameter int TIMEOUT   = 10000000,
  parameter int CNT_W     = 8,
  localparam int SONG_W   = clog2(NUM_SONGS),
  localparam int ADDR_W   = clog2(SONG_LEN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                song_next,
  input  logic                song_prev,
  input  logic [NUM_KEYS-1:0] switches,
  input  logic [OCT_W-1:0]    octave_learn,
  output logic [SONG_W-1:0]   rom_song,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [NOTE_W-1:0]   rom_note,
  input  logic [OCT_W-1:0]    rom_oct,
  output logic [NOTE_W-1:0]   note_to_play,
  output logic [OCT_W-1:0]    octave_out,
  output logic [NUM_KEYS-1:0] led_out,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic                song_done
);

  localparam int TMR_W = clog2(TIMEOUT + 1);
  localparam bit TMR_EN = TIMEOUT > 0;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NOTE_W-1:0] END_CODE =
    NOTE_W'(NOTE_END);
  localparam logic [NOTE_W-1:0] REST_CODE =
    NOTE_W'(NOTE_REST);
  localparam logic [NOTE_W-1:0] MAX_CODE =
    NOTE_W'(NUM_KEYS);
  localparam logic [ADDR_W-1:0] LAST_POS =
    ADDR_W'(SONG_LEN - 1);
  localparam logic [SONG_W-1:0] LAST_SONG =
    SONG_W'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    miss_q, miss_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic [1:0]          sel_rise;
  logic [0:0]          press_rise;
  logic                any_key;
  logic [NUM_KEYS-1:0] expect_led;
  logic                is_hit;
  logic                is_tmo;

  assign any_key = |switches;

  learn_edge_det #(.W(2)) u_sel_edge (
    .clk   (clk),
    .rst_n (reset),
    .d     ({song_prev, song_next}),
    .rise  (sel_rise)
  );

  // A press is the whole keyboard leaving the all-released state.
  learn_edge_det #(.W(1)) u_key_edge (
    .clk   (clk),
    .rst_n (reset),
    .d     (any_key),
    .rise  (press_rise)
  );

  assign expect_led =
    NUM_KEYS'(1) << (note_q - NOTE_W'(1));
  assign is_hit = (switches == expect_led) &&
                  (octave_learn == oct_q);
  assign is_tmo = TMR_EN && (tmr_q == TMR_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pos_q   <= '0;
      song_q  <= '0;
      note_q  <= '0;
      oct_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      song_q  <= song_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    song_d  = song_q;
    note_d  = note_q;
    oct_d   = oct_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    tmr_d   = '0;
    unique case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        note_d = rom_note;
        oct_d  = rom_oct;
        if (rom_note == END_CODE ||
            rom_note > MAX_CODE)
          state_d = S_DONE;
        else if (rom_note == REST_CODE)
          state_d = S_ADV;
        else
          state_d = S_PROMPT;
      end
      S_PROMPT: begin
        // A hit outranks a timeout landing on the same cycle.
        if (press_rise[0] && is_hit) begin
          if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
          state_d = S_RELEASE;
        end else if (press_rise[0]) begin
          if (miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
        end else if (is_tmo) begin
          if (miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
          state_d = S_RELEASE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!any_key) state_d = S_ADV;
      end
      S_ADV: begin
        if (pos_q == LAST_POS) begin
          state_d = S_DONE;
        end else begin
          pos_d   = pos_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_FETCH;
    endcase
    if (|sel_rise) begin
      unique case (1'b1)
        sel_rise[0]:
          song_d = (song_q == LAST_SONG) ?
                   '0 : song_q + 1'b1;
        default:
          song_d = (song_q == '0) ?
                   LAST_SONG : song_q - 1'b1;
      endcase
      pos_d   = '0;
      hit_d   = '0;
      miss_d  = '0;
      tmr_d   = '0;
      state_d = S_FETCH;
    end
  end

  always_comb begin
    note_to_play = '0;
    octave_out   = '0;
    led_out      = '0;
    song_done    = 1'b0;
    unique case (state_q)
      S_PROMPT: begin
        note_to_play = note_q;
        octave_out   = oct_q;
        led_out      = expect_led;
      end
      S_DONE:  song_done = 1'b1;
      default: ;
    endcase
  end

  assign rom_song = song_q;
  assign rom_addr = pos_q;
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_learn_tutor.sv
// Self-checking bench for learn_tutor: directed table,
// hand sequences and randomized songs against a note-level model.
module tb_learn_tutor;

  localparam int NK = 7;
  localparam int NS = 3;
  localparam int SL = 8;
  localparam int CMAX = 7;

  logic       clk;
  logic       reset;
  logic       song_next;
  logic       song_prev;
  logic [6:0] switches;
  logic [1:0] octave_learn;
  logic [1:0] rom_song;
  logic [2:0] rom_addr;
  logic [3:0] rom_note;
  logic [1:0] rom_oct;
  logic [3:0] note_to_play;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [2:0] hit_cnt;
  logic [2:0] miss_cnt;
  logic       song_done;

  learn_tutor #(
    .NUM_KEYS  (NK),
    .NUM_SONGS (NS),
    .SONG_LEN  (SL),
    .NOTE_W    (4),
    .OCT_W     (2),
    .TIMEOUT   (20),
    .CNT_W     (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .song_next    (song_next),
    .song_prev    (song_prev),
    .switches     (switches),
    .octave_learn (octave_learn),
    .rom_song     (rom_song),
    .rom_addr     (rom_addr),
    .rom_note     (rom_note),
    .rom_oct      (rom_oct),
    .note_to_play (note_to_play),
    .octave_out   (octave_out),
    .led_out      (led_out),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .song_done    (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song library: synchronous read, one cycle latency.
  logic [3:0] mem_note [NS][SL];
  logic [1:0] mem_oct  [NS][SL];

  always @(posedge clk) begin
    if (int'(rom_song) < NS) begin
      rom_note <= mem_note[rom_song][rom_addr];
      rom_oct  <= mem_oct[rom_song][rom_addr];
    end else begin
      rom_note <= 4'hF;
      rom_oct  <= 2'd0;
    end
  end

  int n_vec;
  int n_err;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_prompt();
    int k;
    k = 0;
    while (led_out == 0 && !song_done && k < 30) begin
      tick();
      k++;
    end
    chk("prompt_wait", int'(k < 30), 1);
  endtask

  task automatic press(input logic [6:0] sw,
                       input logic [1:0] oc);
    switches     = sw;
    octave_learn = oc;
    tick();
    switches = '0;
    tick();
  endtask

  task automatic pulse_next();
    song_next = 1'b1;
    tick();
    song_next = 1'b0;
    tick();
  endtask

  task automatic pulse_prev();
    song_prev = 1'b1;
    tick();
    song_prev = 1'b0;
    tick();
  endtask

  task automatic set_song(input int s, input int idx,
                          input int n, input int o);
    mem_note[s][idx] = 4'(n);
    mem_oct[s][idx]  = 2'(o);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  typedef struct {
    logic [6:0] sw;
    logic [1:0] oct;
    int         hit;
    int         miss;
    logic [6:0] led;
    logic       done;
  } row_t;

  row_t rows [6];

  int          cur;
  int          eh;
  int          em;
  int          pn [$];
  int          po [$];
  int          r;
  int          nw;
  logic [6:0]  exp_led;
  logic [6:0]  wsw;

  initial begin
    n_vec = 0;
    n_err = 0;
    rows[0] = '{7'b0000010, 2'd1, 0, 1, 7'b0000100, 1'b0};
    rows[1] = '{7'b0000100, 2'd0, 0, 2, 7'b0000100, 1'b0};
    rows[2] = '{7'b0000110, 2'd1, 0, 3, 7'b0000100, 1'b0};
    rows[3] = '{7'b0000100, 2'd1, 1, 3, 7'b0010000, 1'b0};
    rows[4] = '{7'b0010000, 2'd2, 2, 3, 7'b0000001, 1'b0};
    rows[5] = '{7'b0000001, 2'd0, 3, 3, 7'b0000000, 1'b1};

    for (int s = 0; s < NS; s++)
      for (int i = 0; i < SL; i++) set_song(s, i, 15, 0);
    set_song(0, 0, 3, 1);
    set_song(0, 1, 0, 0);
    set_song(0, 2, 5, 2);
    set_song(0, 3, 1, 0);
    set_song(1, 0, 7, 2);
    set_song(2, 0, 5, 0);
    set_song(2, 1, 2, 3);

    reset        = 1'b0;
    song_next    = 1'b0;
    song_prev    = 1'b0;
    switches     = '0;
    octave_learn = '0;
    #1;
    chk("rst_led", int'(led_out), 0);
    chk("rst_note", int'(note_to_play), 0);
    chk("rst_done", int'(song_done), 0);
    chk("rst_song", int'(rom_song), 0);
    chk("rst_hit", int'(hit_cnt), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("fetch_addr", int'(rom_addr), 0);

    // Prompt appears two cycles after FETCH.
    tick();
    chk("lat_wait_led", int'(led_out), 0);
    tick();
    chk("lat_led", int'(led_out), 'b0000100);
    chk("lat_note", int'(note_to_play), 3);
    chk("lat_oct", int'(octave_out), 1);

    // Timeout of 20 cycles with no press.
    repeat (19) tick();
    chk("tmo_pre_miss", int'(miss_cnt), 0);
    chk("tmo_pre_led", int'(led_out), 'b0000100);
    tick();
    chk("tmo_miss", int'(miss_cnt), 1);
    chk("tmo_led", int'(led_out), 0);
    wait_prompt();
    chk("tmo_next_led", int'(led_out), 'b0010000);
    chk("tmo_addr", int'(rom_addr), 2);

    // Asynchronous reset in the middle of a prompt.
    reset = 1'b0;
    #1;
    chk("mid_rst_led", int'(led_out), 0);
    chk("mid_rst_note", int'(note_to_play), 0);
    chk("mid_rst_miss", int'(miss_cnt), 0);
    chk("mid_rst_addr", int'(rom_addr), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rerun_led", int'(led_out), 'b0000100);

    for (int i = 0; i < 6; i++) begin
      press(rows[i].sw, rows[i].oct);
      wait_prompt();
      chk($sformatf("row%0d_hit", i),
          int'(hit_cnt), rows[i].hit);
      chk($sformatf("row%0d_miss", i),
          int'(miss_cnt), rows[i].miss);
      chk($sformatf("row%0d_led", i),
          int'(led_out), int'(rows[i].led));
      chk($sformatf("row%0d_done", i),
          int'(song_done), int'(rows[i].done));
    end

    // Previous from song 0 wraps to the last song.
    pulse_prev();
    chk("prev_song", int'(rom_song), 2);
    chk("prev_hit", int'(hit_cnt), 0);
    chk("prev_miss", int'(miss_cnt), 0);
    chk("prev_done", int'(song_done), 0);
    wait_prompt();
    chk("s2_led", int'(led_out), 'b0010000);

    // Keys held across a hit score only once.
    switches     = 7'b0010000;
    octave_learn = 2'd0;
    tick();
    chk("hold_hit", int'(hit_cnt), 1);
    repeat (4) tick();
    chk("hold_hit2", int'(hit_cnt), 1);
    chk("hold_led", int'(led_out), 0);
    switches = '0;
    tick();
    switches     = 7'b0000010;
    octave_learn = 2'd3;
    wait_prompt();
    chk("held_entry_led", int'(led_out), 'b0000010);
    repeat (3) tick();
    chk("held_entry_hit", int'(hit_cnt), 1);
    chk("held_entry_miss", int'(miss_cnt), 0);
    switches = '0;
    tick();
    switches = 7'b0000010;
    tick();
    chk("held_rel_hit", int'(hit_cnt), 2);
    switches = '0;
    wait_prompt();
    chk("s2_done", int'(song_done), 1);

    // Simultaneous next and prev: next wins.
    song_next = 1'b1;
    song_prev = 1'b1;
    tick();
    chk("both_song", int'(rom_song), 0);
    chk("both_hit", int'(hit_cnt), 0);
    song_next = 1'b0;
    song_prev = 1'b0;
    tick();
    pulse_next();
    chk("next_song", int'(rom_song), 1);
    wait_prompt();
    chk("s1_led", int'(led_out), 'b1000000);
    chk("s1_oct", int'(octave_out), 2);

    // Randomized songs against a note-level model.
    cur = 1;
    for (int rd = 0; rd < 8; rd++) begin
      for (int s = 0; s < NS; s++) begin
        for (int i = 0; i < SL; i++) begin
          r = $urandom_range(0, 19);
          if (r < 14)      set_song(s, i, (r % 7) + 1,
                                    $urandom_range(0, 3));
          else if (r < 17) set_song(s, i, 0, 0);
          else if (r < 18) set_song(s, i, 15, 0);
          else             set_song(s, i, 8 + (r % 7), 0);
        end
      end
      pulse_next();
      cur = (cur + 1) % NS;
      eh  = 0;
      em  = 0;
      chk("rnd_song", int'(rom_song), cur);
      pn.delete();
      po.delete();
      for (int i = 0; i < SL; i++) begin
        if (mem_note[cur][i] > 4'd7) break;
        if (mem_note[cur][i] != 4'd0) begin
          pn.push_back(int'(mem_note[cur][i]));
          po.push_back(int'(mem_oct[cur][i]));
        end
      end
      for (int p = 0; p < pn.size(); p++) begin
        wait_prompt();
        exp_led = 7'(1 << (pn[p] - 1));
        chk("rnd_led", int'(led_out), int'(exp_led));
        chk("rnd_note", int'(note_to_play), pn[p]);
        chk("rnd_oct", int'(octave_out), po[p]);
        nw = $urandom_range(0, 3);
        for (int w = 0; w < nw; w++) begin
          if ($urandom_range(0, 1) == 0) begin
            wsw = 7'($urandom_range(1, 127));
            while (wsw == exp_led)
              wsw = 7'($urandom_range(1, 127));
            press(wsw, 2'(po[p]));
          end else begin
            press(exp_led, 2'((po[p] + 1) % 4));
          end
          em = sat(em + 1);
          chk("rnd_miss", int'(miss_cnt), em);
        end
        press(exp_led, 2'(po[p]));
        eh = sat(eh + 1);
        chk("rnd_hit", int'(hit_cnt), eh);
      end
      wait_prompt();
      chk("rnd_done", int'(song_done), 1);
      chk("rnd_end_hit", int'(hit_cnt), eh);
      chk("rnd_end_miss", int'(miss_cnt), em);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
